// File: rtl/acc_host_driver.sv
// acc_host_driver
//   Host-side sequencer for a byte-serial divide accelerator. A 16/16 division
//   job is accepted on the request handshake. Four operand bytes are streamed to
//   the accelerator, four result bytes are popped back, and the quotient and
//   remainder are presented on the response handshake. If the accelerator stays
//   idle for too long, the job is aborted and flagged with RespErr.
//
// Ports
//   clk, RstN                              clock; asynchronous active-low reset
//   ReqValid, ReqReady, Dividend, Divisor  job request handshake and operands
//   StartData, ReadyToAccept, BusDataIn    operand byte stream to the accelerator
//   OutBuffFull, ReceiveData, BusDataOut   result byte stream from the accelerator
//   RespValid, RespReady, Q, R, RespErr    result handshake, quotient, remainder,
//                                          timeout flag
module acc_host_driver #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        RstN,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [15:0] Dividend,
    input  logic [15:0] Divisor,
    output logic        StartData,
    input  logic        ReadyToAccept,
    output logic [7:0]  BusDataIn,
    input  logic        OutBuffFull,
    output logic        ReceiveData,
    input  logic [7:0]  BusDataOut,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        RespErr
);

    localparam int             CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [15:0]    job_dd, job_dv;
    logic [1:0]     idx;
    logic [CW-1:0]  tcnt;
    logic [15:0]    q_val, r_val;
    logic           err_flag;
    logic           rd;

    logic           accept, send_xfer, recv_cap, last_byte, timed_out;

    assign accept    = (state == IDLE) && ReqValid;
    assign send_xfer = (state == SEND) && ReadyToAccept;
    // a result byte is taken in the cycle ReceiveData is high
    assign recv_cap  = (state == RECV) && rd;
    assign last_byte = (idx == 2'd3);
    // idle cycle with the counter already at the limit: abort at this edge
    assign timed_out = (((state == SEND) && !ReadyToAccept) ||
                        ((state == RECV) && !rd)) && (tcnt == TMAX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: begin
                if (send_xfer && last_byte) state_nxt = RECV;
                else if (timed_out)         state_nxt = DONE;
            end
            RECV: begin
                if (recv_cap && last_byte) state_nxt = DONE;
                else if (timed_out)        state_nxt = DONE;
            end
            DONE: if (RespReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            job_dd   <= '0;
            job_dv   <= '0;
            idx      <= '0;
            tcnt     <= '0;
            q_val    <= '0;
            r_val    <= '0;
            err_flag <= 1'b0;
            rd       <= 1'b0;
        end else begin
            rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        job_dd   <= Dividend;
                        job_dv   <= Divisor;
                        idx      <= '0;
                        tcnt     <= '0;
                        q_val    <= '0;
                        r_val    <= '0;
                        err_flag <= 1'b0;
                    end
                end
                SEND: begin
                    if (send_xfer) begin
                        // 2-bit index wraps to 0 after the fourth byte
                        idx  <= idx + 2'd1;
                        tcnt <= '0;
                    end else if (timed_out) begin
                        tcnt     <= '0;
                        err_flag <= 1'b1;
                        q_val    <= '0;
                        r_val    <= '0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RECV: begin
                    // one-cycle pop, never back to back; suppressed when aborting
                    rd <= OutBuffFull && !rd && !timed_out;
                    if (recv_cap) begin
                        case (idx)
                            2'd0:    q_val[7:0]  <= BusDataOut;
                            2'd1:    q_val[15:8] <= BusDataOut;
                            2'd2:    r_val[7:0]  <= BusDataOut;
                            default: r_val[15:8] <= BusDataOut;
                        endcase
                        idx  <= idx + 2'd1;
                        tcnt <= '0;
                    end else if (timed_out) begin
                        // drop any partially collected result
                        tcnt     <= '0;
                        err_flag <= 1'b1;
                        q_val    <= '0;
                        r_val    <= '0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    always_comb begin
        BusDataIn = '0;
        if (state == SEND) begin
            case (idx)
                2'd0:    BusDataIn = job_dd[7:0];
                2'd1:    BusDataIn = job_dd[15:8];
                2'd2:    BusDataIn = job_dv[7:0];
                default: BusDataIn = job_dv[15:8];
            endcase
        end
    end

    assign ReqReady    = (state == IDLE);
    assign StartData   = (state == SEND);
    assign RespValid   = (state == DONE);
    assign ReceiveData = rd;
    assign Q           = q_val;
    assign R           = r_val;
    assign RespErr     = err_flag;

    // ---------------------------------------------------------- properties
    a_rd_single : assert property (@(posedge clk) disable iff (!RstN)
        ReceiveData |=> !ReceiveData);
    a_rd_not_in_send : assert property (@(posedge clk) disable iff (!RstN)
        StartData |-> !ReceiveData);
    a_resp_hold : assert property (@(posedge clk) disable iff (!RstN)
        (RespValid && !RespReady) |=> (RespValid && $stable(Q) && $stable(R) && $stable(RespErr)));

endmodule

// File: tb/tb_acc_host_driver.sv
// Randomized scoreboard bench for acc_host_driver. A behavioural accelerator
// model consumes operand bytes and returns quotient/remainder bytes; the host
// pushes the arithmetic expectation for each accepted job, and an independent
// monitor pops and compares on every response handshake.
module tb_acc_host_driver;

    localparam int TMO = 15;

    logic        clk, RstN;
    logic        ReqValid, ReqReady;
    logic [15:0] Dividend, Divisor;
    logic        StartData, ReadyToAccept;
    logic [7:0]  BusDataIn;
    logic        OutBuffFull, ReceiveData;
    logic [7:0]  BusDataOut;
    logic        RespValid, RespReady;
    logic [15:0] Q, R;
    logic        RespErr;

    acc_host_driver #(.TIMEOUT(TMO)) dut (
        .clk(clk), .RstN(RstN),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Dividend(Dividend), .Divisor(Divisor),
        .StartData(StartData), .ReadyToAccept(ReadyToAccept), .BusDataIn(BusDataIn),
        .OutBuffFull(OutBuffFull), .ReceiveData(ReceiveData), .BusDataOut(BusDataOut),
        .RespValid(RespValid), .RespReady(RespReady),
        .Q(Q), .R(R), .RespErr(RespErr)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          xfer_base;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int total_xfers = 0;
    int last_xfer_edge = 0;
    bit acc_stuck = 0;
    bit rta_toggle = 0;
    bit obf_noise = 0;
    bit hold_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a divider returns floor quotient and remainder; on a zero
    // divisor the accelerator returns all-ones and the dividend, passed through.
    function automatic exp_t ref_div(input logic [15:0] dd, input logic [15:0] dv,
                                     input bit stuck, input int base);
        exp_t e;
        e.xfer_base = base;
        e.err = 1'b0;
        if (stuck) begin
            e.q = 16'h0; e.r = 16'h0; e.err = 1'b1;
        end else if (dv == 16'h0) begin
            e.q = 16'hFFFF; e.r = dd;
        end else begin
            e.q = dd / dv; e.r = dd % dv;
        end
        return e;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

    // ------------------------------------------------ accelerator model
    initial begin : accel
        logic [7:0]  rx[$];
        logic [7:0]  res_q[$];
        logic [7:0]  sent;
        logic [15:0] a, b, qq, rr;
        int          dly, low_run;
        bit          prev_rd, xfer, pop;
        ReadyToAccept = 1'b0; OutBuffFull = 1'b0; BusDataOut = 8'h0;
        dly = 0; low_run = 0; prev_rd = 0;
        forever begin
            @(negedge clk);
            xfer = RstN && StartData && ReadyToAccept;
            pop  = RstN && ReceiveData;
            sent = BusDataIn;
            if (RstN && ReceiveData)
                chk("rd_protocol", {prev_rd, StartData, OutBuffFull}, 3'b001);
            prev_rd = RstN && ReceiveData;
            @(posedge clk); #1;
            if (!RstN) begin
                rx.delete(); res_q.delete(); dly = 0; prev_rd = 0;
                ReadyToAccept = 1'b0; OutBuffFull = 1'b0; BusDataOut = 8'h0;
            end else begin
                if (xfer) begin
                    total_xfers++;
                    last_xfer_edge = cyc;
                    if (exp_bytes.size() == 0) chk("send_pending", exp_bytes.size(), 1);
                    else                       chk("send_byte", sent, exp_bytes.pop_front());
                    rx.push_back(sent);
                    if (rx.size() == 4) begin
                        a  = {rx[1], rx[0]};
                        b  = {rx[3], rx[2]};
                        qq = (b == 16'h0) ? 16'hFFFF : a / b;
                        rr = (b == 16'h0) ? a : a % b;
                        if (!acc_stuck) begin
                            res_q.push_back(qq[7:0]);  res_q.push_back(qq[15:8]);
                            res_q.push_back(rr[7:0]);  res_q.push_back(rr[15:8]);
                            dly = $urandom_range(0, 4);
                        end
                        rx.delete();
                    end
                end
                if (pop && res_q.size() > 0) begin
                    res_q.delete(0);
                    dly = $urandom_range(0, 2);
                end else if (dly > 0) begin
                    dly--;
                end
                OutBuffFull = (res_q.size() > 0 && dly == 0) ||
                              (obf_noise && StartData && $urandom_range(0, 1) == 1);
                BusDataOut  = (res_q.size() > 0) ? res_q[0] : 8'($urandom);
                if (rta_toggle)        ReadyToAccept = !ReadyToAccept;
                else if (low_run >= 3) ReadyToAccept = 1'b1;
                else                   ReadyToAccept = ($urandom_range(0, 1) == 1);
                low_run = ReadyToAccept ? 0 : low_run + 1;
            end
        end
    end

    // ----------------------------------------------------- response monitor
    initial begin : monitor
        exp_t        e;
        bit          pvalid, chk_idle;
        logic [32:0] held;
        pvalid = 0; chk_idle = 0; held = '0;
        RespReady = 1'b0;
        forever begin
            @(negedge clk);
            if (!RstN) begin
                exp_q.delete(); pvalid = 0; chk_idle = 0;
            end else begin
                if (chk_idle) chk("idle_after_resp", ReqReady, 1);
                chk_idle = 0;
                if (RespValid) begin
                    if (pvalid)
                        chk("done_hold", {Q, R, RespErr}, held);
                    else if (exp_q.size() > 0 && exp_q[0].err)
                        chk("timeout_latency", cyc - last_xfer_edge, TMO + 1);
                    if (RespReady) begin
                        if (exp_q.size() == 0) begin
                            chk("resp_unexpected", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("resp_q",     Q,       e.q);
                            chk("resp_r",     R,       e.r);
                            chk("resp_err",   RespErr, e.err);
                            chk("xfer_count", total_xfers - e.xfer_base, 4);
                        end
                        chk_idle = 1; pvalid = 0;
                    end else begin
                        pvalid = 1; held = {Q, R, RespErr};
                    end
                end else begin
                    pvalid = 0;
                end
            end
            @(posedge clk); #1;
            RespReady = !hold_rdy && ($urandom_range(0, 2) != 0);
        end
    end

    // ------------------------------------------------------------- host
    task automatic issue(input logic [15:0] dd, input logic [15:0] dv);
        bit got = 0;
        Dividend = dd; Divisor = dv; ReqValid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ReqReady) begin
                exp_q.push_back(ref_div(dd, dv, acc_stuck, total_xfers));
                exp_bytes.push_back(dd[7:0]);  exp_bytes.push_back(dd[15:8]);
                exp_bytes.push_back(dv[7:0]);  exp_bytes.push_back(dv[15:8]);
                got = 1;
            end
            @(posedge clk); #1;
        end
        ReqValid = 1'b0;
        if (!got) chk("req_accept_bound", ReqReady, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ReqReady) ok = 1;
        end
        if (!ok) chk({name, "_drain"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin : host
        logic [15:0] dd, dv;
        int          b, sel;
        bit          hit;
        RstN = 1'b0; ReqValid = 1'b0; Dividend = 16'h0; Divisor = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus",    {StartData, ReceiveData, BusDataIn}, 0);
        chk("rst_resp",   {RespValid, RespErr}, 0);
        chk("rst_qr",     {Q, R}, 0);
        chk("rst_reqrdy", ReqReady, 1);
        #3 RstN = 1'b1;
        @(negedge clk);
        chk("ready_after_release", ReqReady, 1);
        @(posedge clk); #1;

        // 1000 / 7: bytes E8 03 07 00, Q=142 R=6
        issue(16'd1000, 16'd7);
        wait_idle("basic");

        // all-ones by one with a toggling accept line
        rta_toggle = 1;
        issue(16'hFFFF, 16'h0001);
        wait_idle("toggle");
        rta_toggle = 0;

        // accelerator never returns a result
        acc_stuck = 1;
        issue(16'd1234, 16'd56);
        wait_idle("timeout");
        acc_stuck = 0;

        // response stalled 10 cycles while junk requests are offered
        hold_rdy = 1;
        issue(16'($urandom), 16'($urandom_range(1, 65535)));
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (RespValid) hit = 1;
        end
        if (!hit) chk("done_reach_bound", RespValid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ReqValid = 1'b1; Dividend = 16'($urandom); Divisor = 16'($urandom);
            @(negedge clk);
            chk("req_ignored_in_done", {ReqReady, RespValid}, 2'b01);
        end
        @(posedge clk); #1;
        ReqValid = 1'b0; hold_rdy = 0;
        wait_idle("hold");

        // reset after the second operand byte
        obf_noise = 1;
        b = total_xfers;
        issue(16'hBEEF, 16'h0013);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (total_xfers >= b + 2) hit = 1;
        end
        if (!hit) chk("two_bytes_bound", total_xfers - b, 2);
        #1 RstN = 1'b0;
        exp_bytes.delete();
        #1;
        chk("midrst_bus",  {StartData, ReceiveData, BusDataIn}, 0);
        chk("midrst_resp", {RespValid, RespErr, Q, R}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_quiet", {StartData, ReceiveData}, 0);
        @(posedge clk); #3 RstN = 1'b1;
        @(negedge clk);
        chk("midrst_ready", ReqReady, 1);
        @(posedge clk); #1;
        issue(16'd50000, 16'd321);
        wait_idle("after_reset");

        // randomized jobs
        for (int j = 0; j < 30; j++) begin
            sel = $urandom_range(0, 7);
            dd  = 16'($urandom);
            if (sel == 0)     dv = 16'h0;
            else if (sel == 1) dv = 16'h1;
            else if (sel < 4)  dv = 16'($urandom_range(1, 255));
            else               dv = 16'($urandom);
            acc_stuck  = ($urandom_range(0, 9) == 0);
            rta_toggle = ($urandom_range(0, 3) == 0);
            issue(dd, dv);
            wait_idle("rand");
            acc_stuck = 0;
        end

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("bytes_empty", exp_bytes.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
